// File: rtl/panda_hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, multicycle, redirect and memory-wait
// events into per-stage stall, bubble and flush controls, plus a saturating stall counter.
module panda_hazard_ctrl #(
  parameter int MC_LATENCY  = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int PERF_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_use_hazard_i,
  input  logic              mc_start_i,
  input  logic              branch_taken_i,
  input  logic              trap_i,
  input  logic              mem_wait_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              bubble_ex_o,
  output logic              bubble_mem_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic              mc_busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int CNT_MAX = (MC_LATENCY > FLUSH_DEPTH) ? MC_LATENCY : FLUSH_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Entry points: the redirecting cycle itself counts as the first flush cycle,
  // and the issuing cycle as the first multicycle stall.
  localparam state_t           REDIR_STATE = (FLUSH_DEPTH > 1) ? FLUSH : IDLE;
  localparam logic [CNT_W-1:0] REDIR_CNT   = (FLUSH_DEPTH > 1) ? CNT_W'(FLUSH_DEPTH - 2) : '0;
  localparam state_t           MC_STATE    = (MC_LATENCY >= 3) ? MC_BUSY : IDLE;
  localparam logic [CNT_W-1:0] MC_CNT      = (MC_LATENCY >= 3) ? CNT_W'(MC_LATENCY - 3) : '0;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              mc_busy_r;
  logic [PERF_W-1:0] stall_cnt_r;
  logic              stall_if_s, stall_id_s, stall_ex_s;
  logic              bubble_ex_s, bubble_mem_s, flush_if_s, flush_id_s;

  // Prioritised event decode and next-state selection.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    stall_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    stall_ex_s   = 1'b0;
    bubble_ex_s  = 1'b0;
    bubble_mem_s = 1'b0;
    flush_if_s   = 1'b0;
    flush_id_s   = 1'b0;
    if (trap_i) begin
      flush_if_s   = 1'b1;
      flush_id_s   = 1'b1;
      bubble_mem_s = 1'b1;
      state_nxt_s  = REDIR_STATE;
      cnt_nxt_s    = REDIR_CNT;
    end else if (mem_wait_i) begin
      stall_if_s = 1'b1;
      stall_id_s = 1'b1;
      stall_ex_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (branch_taken_i) begin
            flush_if_s  = 1'b1;
            flush_id_s  = 1'b1;
            state_nxt_s = REDIR_STATE;
            cnt_nxt_s   = REDIR_CNT;
          end else if (mc_start_i) begin
            stall_if_s   = 1'b1;
            stall_id_s   = 1'b1;
            stall_ex_s   = 1'b1;
            bubble_mem_s = 1'b1;
            state_nxt_s  = MC_STATE;
            cnt_nxt_s    = MC_CNT;
          end else if (load_use_hazard_i) begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MC_BUSY: begin
          stall_if_s   = 1'b1;
          stall_id_s   = 1'b1;
          stall_ex_s   = 1'b1;
          bubble_mem_s = 1'b1;
          if (cnt_r == '0) begin
            state_nxt_s = IDLE;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (branch_taken_i) begin
            flush_if_s  = 1'b1;
            flush_id_s  = 1'b1;
            state_nxt_s = REDIR_STATE;
            cnt_nxt_s   = REDIR_CNT;
          end else if (cnt_r == '0) begin
            flush_if_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            flush_if_s = 1'b1;
            cnt_nxt_s  = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // FSM state, counter and performance counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      mc_busy_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mc_busy_r <= (state_nxt_s == MC_BUSY);
      if (stall_if_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + PERF_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign stall_if_o   = rst_ni & stall_if_s;
  assign stall_id_o   = rst_ni & stall_id_s;
  assign stall_ex_o   = rst_ni & stall_ex_s;
  assign bubble_ex_o  = rst_ni & bubble_ex_s;
  assign bubble_mem_o = rst_ni & bubble_mem_s;
  assign flush_if_o   = rst_ni & flush_if_s;
  assign flush_id_o   = rst_ni & flush_id_s;
  assign mc_busy_o    = mc_busy_r;
  assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_panda_hazard_ctrl.sv
// Directed bench for panda_hazard_ctrl (MC_LATENCY=4, FLUSH_DEPTH=2, PERF_W=4).
module tb_panda_hazard_ctrl;

  logic       clk, rst_n;
  logic       lu, mc, br, tr, mw;
  logic       stall_if, stall_id, stall_ex, bubble_ex, bubble_mem;
  logic       flush_if, flush_id, mc_busy;
  logic [3:0] stall_cnt;
  logic [7:0] obs;
  logic [3:0] exp_sc;
  int         total, bad;

  panda_hazard_ctrl #(.MC_LATENCY(4), .FLUSH_DEPTH(2), .PERF_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .load_use_hazard_i(lu), .mc_start_i(mc), .branch_taken_i(br),
    .trap_i(tr), .mem_wait_i(mw),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .bubble_ex_o(bubble_ex), .bubble_mem_o(bubble_mem),
    .flush_if_o(flush_if), .flush_id_o(flush_id),
    .mc_busy_o(mc_busy), .stall_cnt_o(stall_cnt)
  );

  assign obs = {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_if, flush_id, mc_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp_o);
    total++;
    assert (obs === exp_o) else begin
      bad++;
      $error("FAIL %s outs got=%b exp=%b", tag, obs, exp_o);
    end
    total++;
    assert (stall_cnt === exp_sc) else begin
      bad++;
      $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, exp_sc);
    end
  endtask

  // in_v = {lu, mc, br, tr, mw}; exp_o = {sif,sid,sex,bex,bmem,fif,fid,busy}
  task automatic step(input string tag, input logic [4:0] in_v, input logic [7:0] exp_o);
    @(posedge clk);
    #1;
    {lu, mc, br, tr, mw} = in_v;
    #3;
    chk(tag, exp_o);
    if (exp_o[7] && exp_sc != 4'd15) exp_sc = exp_sc + 4'd1;
  endtask

  initial begin
    total = 0; bad = 0; exp_sc = 4'd0;
    rst_n = 1'b0;
    {lu, mc, br, tr, mw} = 5'b11111;
    @(posedge clk); @(posedge clk);
    #3;
    chk("reset_hold", 8'b0000_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    {lu, mc, br, tr, mw} = 5'b00000;
    #3;
    chk("reset_release", 8'b0000_0000);

    // multicycle op: 3 stall cycles, busy in cycles 2-3
    step("idle0",     5'b00000, 8'b0000_0000);
    step("mc_issue",  5'b01000, 8'b1110_1000);
    step("mc_busy1",  5'b00000, 8'b1110_1001);
    step("mc_busy2",  5'b00000, 8'b1110_1001);
    step("mc_done",   5'b00000, 8'b0000_0000);
    // branch redirect: 2 flush_if, 1 flush_id
    step("br_taken",  5'b00100, 8'b0000_0110);
    step("br_flush",  5'b00000, 8'b0000_0100);
    step("br_done",   5'b00000, 8'b0000_0000);
    // load-use alone and under mem_wait
    step("lu",        5'b10000, 8'b1101_0000);
    step("lu_mw",     5'b10001, 8'b1110_0000);
    step("lu_done",   5'b00000, 8'b0000_0000);
    // lu/mc/branch ignored while busy
    step("mc2_issue", 5'b01000, 8'b1110_1000);
    step("mc2_ign",   5'b11100, 8'b1110_1001);
    step("mc2_busy2", 5'b00000, 8'b1110_1001);
    step("mc2_done",  5'b00000, 8'b0000_0000);
    // trap aborts the multicycle op
    step("mc3_issue", 5'b01000, 8'b1110_1000);
    step("mc3_trap",  5'b00010, 8'b0000_1111);
    step("trap_fl",   5'b00000, 8'b0000_0100);
    step("trap_done", 5'b00000, 8'b0000_0000);
    // trap beats everything; redirect in FLUSH restarts; mem_wait freezes FLUSH
    step("trap_all",  5'b01111, 8'b0000_1110);
    step("fl_br",     5'b00100, 8'b0000_0110);
    step("fl_mw",     5'b00001, 8'b1110_0000);
    step("fl_last",   5'b00000, 8'b0000_0100);
    step("fl_done",   5'b00000, 8'b0000_0000);
    // mem_wait during MC_BUSY extends the op; counter saturates at 15
    step("mc4_issue", 5'b01000, 8'b1110_1000);
    step("mc4_mw1",   5'b00001, 8'b1110_0001);
    step("mc4_mw2",   5'b00001, 8'b1110_0001);
    step("mc4_mw3",   5'b00001, 8'b1110_0001);
    step("mc4_busy1", 5'b00000, 8'b1110_1001);
    step("mc4_busy2", 5'b00000, 8'b1110_1001);
    step("mc4_sat",   5'b00000, 8'b0000_0000);
    // reset pulse mid-op
    step("mc5_issue", 5'b01000, 8'b1110_1000);
    step("mc5_busy1", 5'b00000, 8'b1110_1001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    {lu, mc, br, tr, mw} = 5'b01001;
    exp_sc = 4'd0;
    #3;
    chk("rst_mid_op", 8'b0000_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    {lu, mc, br, tr, mw} = 5'b00000;
    #3;
    chk("post_rst_idle", 8'b0000_0000);
    step("post_rst_lu",   5'b10000, 8'b1101_0000);
    step("post_rst_done", 5'b00000, 8'b0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
